// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the clearable dual-port RAM.
package ram_pkg;

  typedef enum logic {StClear, StIdle} state_e;

  localparam int unsigned DefDataW = 4;
  localparam int unsigned DefAddrW = 4;

  function automatic int unsigned depth_of(int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_dp_clr_if.sv
// User-side bus of ram_dp_clr: write port, read port, clear request and status.
interface ram_dp_clr_if
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) ();

  logic              csRAM;
  logic              weRAM;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              clear;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;

  modport master (
    output csRAM, weRAM, wr_addr, data_in, rd_en, rd_addr, clear,
    input  data_out, rd_valid, busy
  );

  modport slave (
    input  csRAM, weRAM, wr_addr, data_in, rd_en, rd_addr, clear,
    output data_out, rd_valid, busy
  );

endinterface

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every address once after reset or a clear request,
// emitting a zero-write strobe and address for the top to mux onto the write port.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int unsigned       DEPTH    = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          // clear is deliberately ignored here; the sweep never restarts itself
          if (clr_ptr_q == LastAddr) begin
            clr_ptr_q <= '0;
            state_q   <= StIdle;
            busy_q    <= 1'b0;
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
        StIdle: begin
          if (clear) begin
            clr_ptr_q <= '0;
            state_q   <= StClear;
            busy_q    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == StClear);
  assign clr_addr = clr_ptr_q;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port synchronous RAM with registered read and hardware zero sweep.
// Build option RAM_WRITE_FIRST_EN: same-address read during write returns data_in.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input logic         clk,
  input logic         reset,
  ram_dp_clr_if.slave bus
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_seq (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.clear),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  logic              access_ok;
  logic              wr_fire;
  logic              rd_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  // A clear request in IDLE wins over any user access in the same cycle
  assign access_ok = !reset && !busy && !bus.clear;
  assign wr_fire   = access_ok && bus.csRAM && bus.weRAM;
  assign rd_fire   = access_ok && bus.csRAM && bus.rd_en;

  always_comb begin
    mem_we    = clr_we || wr_fire;
    mem_addr  = bus.wr_addr;
    mem_wdata = bus.data_in;
    if (clr_we) begin
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

`ifdef RAM_WRITE_FIRST_EN
  assign rd_word = (wr_fire && (bus.wr_addr == bus.rd_addr)) ? bus.data_in : mem[bus.rd_addr];
`else
  assign rd_word = mem[bus.rd_addr];
`endif

  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_fire) begin
      data_out_q <= rd_word;
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: vector table plus sweep/reset/clear sequences,
// read data checked through a scoreboard queue.
module tb_ram_dp_clr;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;

`ifdef RAM_WRITE_FIRST_EN
  localparam logic [3:0] SameAddrExp = 4'h5;
`else
  localparam logic [3:0] SameAddrExp = 4'h2;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ram_dp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_dp_clr #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       cs;
    logic       we;
    logic [3:0] wa;
    logic [3:0] din;
    logic       re;
    logic [3:0] ra;
    logic       clr;
    logic       rst;
    logic [3:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] sb [$];
  logic       m_busy;
  logic [3:0] m_ptr;
  logic [3:0] m_dout = 4'h0;

  function automatic vec_t mk(input logic cs, input logic we, input logic [3:0] wa,
                              input logic [3:0] din, input logic re, input logic [3:0] ra,
                              input logic clr, input logic rst, input logic [3:0] exp);
    vec_t v;
    v.cs = cs; v.we = we; v.wa = wa; v.din = din; v.re = re; v.ra = ra;
    v.clr = clr; v.rst = rst; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive v, predict, then check busy/rd_valid/data_out after the edge
  task automatic cyc(input vec_t v);
    logic       rd_exp;
    logic [3:0] want;
    bus.csRAM   = v.cs;
    bus.weRAM   = v.we;
    bus.wr_addr = v.wa;
    bus.data_in = v.din;
    bus.rd_en   = v.re;
    bus.rd_addr = v.ra;
    bus.clear   = v.clr;
    reset       = v.rst;
    rd_exp = !v.rst && !m_busy && !v.clr && v.cs && v.re;
    if (rd_exp) sb.push_back(v.exp);
    if (v.rst) begin
      m_busy = 1'b1;
      m_ptr  = 4'h0;
      m_dout = 4'h0;
    end else if (m_busy) begin
      if (m_ptr == 4'hF) begin
        m_busy = 1'b0;
        m_ptr  = 4'h0;
      end else begin
        m_ptr = m_ptr + 4'h1;
      end
    end else if (v.clr) begin
      m_busy = 1'b1;
      m_ptr  = 4'h0;
    end
    if (rd_exp) m_dout = v.exp;
    @(posedge clk);
    @(negedge clk);
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("rd_valid", 32'(bus.rd_valid), 32'(rd_exp));
    if (bus.rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_pulse: got pulse with data %0h, expected none", bus.data_out);
      end else begin
        want = sb.pop_front();
        chk("rd_data", 32'(bus.data_out), 32'(want));
      end
    end else if (rd_exp) begin
      want = sb.pop_front();
    end
    chk("data_out", 32'(bus.data_out), 32'(m_dout));
  endtask

  // Apply v every cycle while the DUT reports busy; the sweep must last 16 cycles
  task automatic wait_sweep(input vec_t v, input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      cyc(v);
      n++;
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  vec_t idle_v;
  vec_t rst_v;
  vec_t tbl [16];

  initial begin
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_v  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);

    tbl[0]  = mk(1, 1, 3,  4'hA, 0, 0,  0, 0, 0);
    tbl[1]  = mk(1, 0, 0,  0,    1, 3,  0, 0, 4'hA);
    tbl[2]  = mk(0, 0, 0,  0,    0, 0,  0, 0, 0);
    tbl[3]  = mk(1, 1, 7,  4'h2, 0, 0,  0, 0, 0);
    tbl[4]  = mk(1, 1, 8,  4'h6, 0, 0,  0, 0, 0);
    tbl[5]  = mk(1, 1, 7,  4'h5, 1, 7,  0, 0, SameAddrExp);
    tbl[6]  = mk(1, 0, 0,  0,    1, 7,  0, 0, 4'h5);
    tbl[7]  = mk(1, 1, 7,  4'h2, 0, 0,  0, 0, 0);
    tbl[8]  = mk(1, 1, 7,  4'h5, 1, 8,  0, 0, 4'h6);
    tbl[9]  = mk(1, 0, 0,  0,    1, 7,  0, 0, 4'h5);
    tbl[10] = mk(0, 1, 3,  4'hC, 1, 3,  0, 0, 0);
    tbl[11] = mk(1, 0, 0,  0,    1, 3,  0, 0, 4'hA);
    tbl[12] = mk(1, 1, 15, 4'hE, 0, 0,  0, 0, 0);
    tbl[13] = mk(1, 0, 0,  0,    1, 15, 0, 0, 4'hE);
    tbl[14] = mk(1, 1, 0,  4'h9, 1, 15, 0, 0, 4'hE);
    tbl[15] = mk(1, 0, 0,  0,    1, 0,  0, 0, 4'h9);

    reset       = 1'b1;
    bus.csRAM   = 1'b0;
    bus.weRAM   = 1'b0;
    bus.wr_addr = '0;
    bus.data_in = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.clear   = 1'b0;
    @(negedge clk);

    // Power-up sweep
    cyc(rst_v);
    cyc(rst_v);
    wait_sweep(idle_v, "sweep_after_reset");
    for (int a = 0; a < 16; a++) cyc(mk(1, 0, 0, 0, 1, 4'(a), 0, 0, 4'h0));

    // Basic write/read, hold, same-cycle collisions, chip select, top address
    for (int i = 0; i < 16; i++) cyc(tbl[i]);

    // Fill with F, then clear together with a write that must be dropped
    for (int a = 0; a < 16; a++) cyc(mk(1, 1, 4'(a), 4'hF, 0, 0, 0, 0, 0));
    for (int a = 0; a < 16; a++) cyc(mk(1, 0, 0, 0, 1, 4'(a), 0, 0, 4'hF));
    cyc(mk(1, 1, 0, 4'h1, 1, 0, 1, 0, 0));
    wait_sweep(mk(1, 1, 5, 4'h7, 1, 5, 1, 0, 0), "sweep_clear_ignores_requests");
    for (int a = 0; a < 16; a++) cyc(mk(1, 0, 0, 0, 1, 4'(a), 0, 0, 4'h0));

    // Reset in sweep cycle 9 restarts the sweep and zeroes data_out
    cyc(mk(1, 1, 5, 4'h3, 0, 0, 0, 0, 0));
    cyc(mk(1, 0, 0, 0, 1, 5, 0, 0, 4'h3));
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 9; i++) cyc(idle_v);
    cyc(rst_v);
    chk("dout_after_reset", 32'(bus.data_out), 32'h0);
    wait_sweep(idle_v, "sweep_restart");
    cyc(mk(1, 0, 0, 0, 1, 5, 0, 0, 4'h0));

    // Held clear: sweep, one idle cycle, then a second sweep
    cyc(mk(1, 1, 2, 4'h4, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    wait_sweep(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "sweep_held_1");
    chk("idle_gap", 32'(bus.busy), 32'h0);
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    wait_sweep(idle_v, "sweep_held_2");
    cyc(mk(1, 0, 0, 0, 1, 2, 0, 0, 4'h0));
    cyc(mk(1, 0, 0, 0, 1, 15, 0, 0, 4'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
